next_state_sequencer: RTL

NEXT_STATE_SEQUENCER -- requirements
Module: next_state_sequencer

---
 rtl/next_state_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/next_state_sequencer.sv
// -----------------------------------------------------------------------------
// next_state_sequencer
//
// Microprogram sequencer. Each rising Clk edge selects the next control state
// (microstore address) from the microword's next-state mode field N:
//   000 dispatch to State_Sel     001 increment (mod 128)
//   010 wait for MOC, then +1     011 jump to CR
//   100 branch to CR on Cond^Inv  101 jump to CR on MOC, else hold
//   110/111 go to state 0
// All outputs come straight from registers.
//
// Optional feature macro: MOC_TIMEOUT_EN
//   When defined, an 8-bit counter tracks consecutive hold cycles in modes
//   010/101. When the counter has reached 255 and MOC is still low, the
//   sequencer escapes to state 127 and raises the sticky Bus_Err flag.
//   When undefined, waits are unbounded and Bus_Err does not exist.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   State_Sel  in 7 dispatch target from instruction encoder (0 = unrecognised)
//   N          in 3 next-state mode field
//   CR         in 7 jump-target field
//   Inv        in   inverts Cond
//   Cond       in   branch condition from ALU flags
//   MOC        in   memory-operation-complete
//   State      out 7 current control state
//   Illegal    out  one-cycle pulse after dispatching an unrecognised instruction
//   Bus_Err    out  sticky memory-timeout flag (MOC_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module next_state_sequencer (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [6:0] State_Sel,
  input  logic [2:0] N,
  input  logic [6:0] CR,
  input  logic       Inv,
  input  logic       Cond,
  input  logic       MOC,
  output logic [6:0] State,
  output logic       Illegal
`ifdef MOC_TIMEOUT_EN
  ,
  output logic       Bus_Err
`endif
);

  localparam logic [2:0] MODE_DISPATCH = 3'b000;
  localparam logic [2:0] MODE_INC      = 3'b001;
  localparam logic [2:0] MODE_MEMWAIT  = 3'b010;
  localparam logic [2:0] MODE_JUMP     = 3'b011;
  localparam logic [2:0] MODE_BRANCH   = 3'b100;
  localparam logic [2:0] MODE_JMOC     = 3'b101;

  localparam logic [6:0] TIMEOUT_STATE = 7'd127;

  logic [6:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [6:0] state_inc;

  // 7-bit addition wraps 127 -> 0 naturally.
  assign state_inc = state_q + 7'd1;

`ifdef MOC_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       hold_wait;
  logic       timeout;

  // A hold is a wait-mode cycle in which MOC has not arrived.
  assign hold_wait = ((N == MODE_MEMWAIT) || (N == MODE_JMOC)) && !MOC;
  // MOC on the 256th edge takes precedence because hold_wait is then low.
  assign timeout   = hold_wait && (cnt_q == 8'hFF);

  always_comb begin
    err_d = err_q | timeout;
    if (hold_wait && !timeout) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
  end
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= 7'd0;
      illegal_q <= 1'b0;
`ifdef MOC_TIMEOUT_EN
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
`ifdef MOC_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    unique case (N)
      MODE_DISPATCH: begin
        state_d   = State_Sel;
        illegal_d = (State_Sel == 7'd0);
      end
      MODE_INC:     state_d = state_inc;
      MODE_MEMWAIT: state_d = MOC ? state_inc : state_q;
      MODE_JUMP:    state_d = CR;
      MODE_BRANCH:  state_d = (Cond ^ Inv) ? CR : state_inc;
      MODE_JMOC:    state_d = MOC ? CR : state_q;
      default:      state_d = 7'd0;
    endcase
`ifdef MOC_TIMEOUT_EN
    if (timeout) begin
      state_d = TIMEOUT_STATE;
    end
`endif
  end

  // Outputs: registered values only
  always_comb begin
    State   = state_q;
    Illegal = illegal_q;
`ifdef MOC_TIMEOUT_EN
    Bus_Err = err_q;
`endif
  end

endmodule
